lcd_timing_controller: RTL and testbench
========================================

// Module: lcd_timing_controller
// PURPOSE
//  Master scan sequencer for the LCD pipeline. Keeps the dot and line counters
//  and the PPU mode state machine (OAM scan / transfer / HBlank / VBlank).
//  Its outputs are LY, the STAT mode and coincidence bits, the VBlank and STAT
//  interrupt requests, and the CPU lock-outs for VRAM and OAM.
//  It sits between the LCDC/STAT/LYC register file and the fetcher, sprite
//  scanner and line-buffer writer.
// PARAMETERS
//  DOTS_PER_LINE  456  dots per scanline, counted 0..455
//  OAM_DOTS       80   length of mode 2 at the start of each visible line
//  XFER_DOTS      172  length of mode 3, fixed with no sprite/SCX penalty
//  VISIBLE_LINES  144  lines 0..143 are drawn
//  TOTAL_LINES    154  lines 144..153 are VBlank
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  dot_en        in   1  dot strobe; counters advance only on cycles with dot_en=1
//  lcd_enable    in   1  LCDC.LCDEnable
//  lyc           in   8  LYC register value
//  int_lyc_en    in   1  STAT.CoincidenceInterrupt enable
//  int_mode2_en  in   1  STAT.Mode2Interrupt enable
//  int_mode1_en  in   1  STAT.Mode1Interrupt enable
//  int_mode0_en  in   1  STAT.Mode0Interrupt enable
//  mode          out  2  STAT.Mode: 0 HBlank, 1 VBlank, 2 OAM, 3 transfer
//  ly            out  8  current line (LY)
//  dot           out  9  dot index within the line
//  coincidence   out  1  (ly == lyc) & lcd_enable
//  stat_irq      out  1  one-cycle STAT interrupt request
//  vblank_irq    out  1  one-cycle VBlank interrupt request
//  line_start    out  1  one-cycle pulse at dot 0 of every line
//  frame_start   out  1  one-cycle pulse at line 0, dot 0
//  oam_locked    out  1  mode==2 | mode==3
//  vram_locked   out  1  mode==3
// BEHAVIOUR
//  Reset values
//   - dot=0, ly=0, mode=0; all pulses and locks 0; stat edge register 0.
//  Disabled LCD (lcd_enable=0)
//   - Next clk: dot=0, ly=0, mode=0, locks 0, no irqs.
//   - Holds there regardless of dot_en.
//   - Dropping the enable mid-line or mid-frame aborts the scan immediately.
//  Enabling
//   - First clk with lcd_enable=1 and dot_en=1 after being disabled loads dot=0, ly=0, mode=2.
//   - That same clk pulses line_start and frame_start.
//  Counters (advance only on clk with dot_en=1 while enabled)
//   - dot: 0..DOTS_PER_LINE-1, then wraps to 0 and ly increments.
//   - ly: wraps from TOTAL_LINES-1 to 0.
//   - dot_en=0 freezes every register. Pulses are 0 on those cycles.
//  Mode state machine (registered; updated in the same clk as the counters)
//   - ly < VISIBLE_LINES:
//       mode 2 for dot 0..OAM_DOTS-1
//       mode 3 for dot OAM_DOTS..OAM_DOTS+XFER_DOTS-1
//       mode 0 for the rest of the line
//   - ly >= VISIBLE_LINES: mode 1 for the whole line.
//  Pulses
//   - line_start: 1 for one clk on the dot_en clk that loads dot=0.
//   - frame_start: same clk when ly also becomes 0.
//   - vblank_irq: 1 for one clk on the clk that loads ly=VISIBLE_LINES, dot=0.
//  STAT interrupt
//   - stat_line = (int_lyc_en&coincidence) | (int_mode0_en&mode==0)
//                 | (int_mode1_en&mode==1) | (int_mode2_en&mode==2).
//   - stat_irq is registered: asserted one clk after stat_line goes 0->1, for one clk.
//   - While stat_line stays 1, a newly active source raises no further irq (STAT blocking).
//   - The stat_line edge register is cleared while the LCD is disabled.
//  Coincidence
//   - Combinational on the registered ly and the live lyc.
//   - A CPU write to LYC can raise stat_irq on any cycle, not only on dot_en cycles.
//  Width rules
//   - dot is 9 bits and never exceeds 455; ly is 8 bits and never exceeds 153.
//   - Comparisons are unsigned.
// TESTING
//  1. reset=1, dot_en=1 -> all outputs 0; after reset drops with lcd_enable=1
//     -> mode=2, ly=0, frame_start=1 on the first enabled dot_en clk.
//  2. dot_en tied 1, line 0 -> mode 2 for 80 clks, mode 3 for 172, mode 0 for 204;
//     line_start again at clk 456.
//  3. Run 143*456 dots -> on the next line wrap ly=144, mode=1, vblank_irq
//     exactly one clk; ly wraps 153->0 with frame_start after 70224 dots total.
//  4. lyc=5, int_lyc_en=1 -> one stat_irq on the clk after ly becomes 5.
//     Also int_mode0_en=1 -> no second stat_irq at line 5's HBlank.
//  5. lcd_enable 1->0 at ly=77, dot=300 -> next clk ly=0, dot=0, mode=0, locks 0.
//     Re-enable -> restarts at line 0 in mode 2.
//  6. dot_en pulses every 4th clk -> counters advance once per 4 clks;
//     vram_locked=1 exactly during mode 3 dots.

Source files
------------

// File: rtl/lcd_timing_controller.sv
// lcd_timing_controller
//
// Master scan sequencer for the LCD pipeline. Owns the dot and line counters
// and the PPU mode state machine (OAM scan / pixel transfer / HBlank / VBlank),
// and derives LY, the STAT mode and coincidence bits, the VBlank and STAT
// interrupt requests, and the CPU lock-outs for VRAM and OAM.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   dot_en          dot strobe; the scan advances only on cycles where it is 1
//   lcd_enable      LCDC.LCDEnable; 0 aborts the scan and parks at line 0, dot 0
//   lyc             LYC register value
//   int_*_en        STAT interrupt source enables (LYC, mode 2, mode 1, mode 0)
//   mode            STAT.Mode (0 HBlank, 1 VBlank, 2 OAM, 3 transfer)
//   ly, dot         current line and dot within the line
//   coincidence     (ly == lyc) while the LCD is enabled
//   stat_irq        one-cycle STAT interrupt request
//   vblank_irq      one-cycle VBlank interrupt request
//   line_start      one-cycle pulse when dot 0 of a line is loaded
//   frame_start     one-cycle pulse when line 0, dot 0 is loaded
//   oam_locked      CPU OAM lock-out (modes 2 and 3)
//   vram_locked     CPU VRAM lock-out (mode 3)
module lcd_timing_controller #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned XFER_DOTS     = 172,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic       int_lyc_en,
    input  logic       int_mode2_en,
    input  logic       int_mode1_en,
    input  logic       int_mode0_en,
    output logic [1:0] mode,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic       coincidence,
    output logic       stat_irq,
    output logic       vblank_irq,
    output logic       line_start,
    output logic       frame_start,
    output logic       oam_locked,
    output logic       vram_locked
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_e;

    localparam logic [8:0] LAST_DOT   = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END    = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END   = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] FIRST_VBL  = 8'(VISIBLE_LINES);
    localparam logic [7:0] LAST_LINE  = 8'(TOTAL_LINES - 1);

    mode_e      mode_q, mode_d;
    logic [8:0] dot_q, dot_d, dot_next;
    logic [7:0] ly_q, ly_d, ly_next;
    logic       running_q, running_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_irq_q, vblank_irq_d;
    logic       oam_locked_q, oam_locked_d;
    logic       vram_locked_q, vram_locked_d;
    logic       stat_line_q, stat_line_d;
    logic       stat_irq_q, stat_irq_d;
    logic       stat_line;

    assign coincidence = lcd_enable && (ly_q == lyc);

    // The STAT line is forced low while disabled so the edge register clears
    // and re-enabling starts from a clean 0 level.
    assign stat_line = lcd_enable &&
                       ((int_lyc_en   && coincidence)          ||
                        (int_mode0_en && mode_q == MODE_HBLANK) ||
                        (int_mode1_en && mode_q == MODE_VBLANK) ||
                        (int_mode2_en && mode_q == MODE_OAM));

    // Scan sequencing. running_q remembers that the scan has been started, so
    // the first dot strobe after enabling restarts at line 0, dot 0 instead of
    // advancing. Mode and locks are decoded from the next counter values so
    // they change in the same clock as the counters.
    always_comb begin
        dot_next      = dot_q;
        ly_next       = ly_q;
        dot_d         = dot_q;
        ly_d          = ly_q;
        mode_d        = mode_q;
        running_d     = running_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        vblank_irq_d  = 1'b0;
        oam_locked_d  = oam_locked_q;
        vram_locked_d = vram_locked_q;

        if (!lcd_enable) begin
            dot_d         = '0;
            ly_d          = '0;
            mode_d        = MODE_HBLANK;
            running_d     = 1'b0;
            oam_locked_d  = 1'b0;
            vram_locked_d = 1'b0;
        end else if (dot_en) begin
            if (!running_q) begin
                dot_next = '0;
                ly_next  = '0;
            end else if (dot_q == LAST_DOT) begin
                dot_next = '0;
                ly_next  = (ly_q == LAST_LINE) ? 8'd0 : ly_q + 8'd1;
            end else begin
                dot_next = dot_q + 9'd1;
                ly_next  = ly_q;
            end

            if (ly_next >= FIRST_VBL) begin
                mode_d = MODE_VBLANK;
            end else if (dot_next < OAM_END) begin
                mode_d = MODE_OAM;
            end else if (dot_next < XFER_END) begin
                mode_d = MODE_XFER;
            end else begin
                mode_d = MODE_HBLANK;
            end

            running_d     = 1'b1;
            dot_d         = dot_next;
            ly_d          = ly_next;
            line_start_d  = (dot_next == 9'd0);
            frame_start_d = (dot_next == 9'd0) && (ly_next == 8'd0);
            vblank_irq_d  = (dot_next == 9'd0) && (ly_next == FIRST_VBL);
            oam_locked_d  = (mode_d == MODE_OAM) || (mode_d == MODE_XFER);
            vram_locked_d = (mode_d == MODE_XFER);
        end
    end

    // The STAT edge detector runs every clock, not only on dot strobes, so an
    // LYC write can raise an interrupt at any time. Holding the line high
    // blocks further requests until it drops.
    always_comb begin
        stat_line_d = stat_line;
        stat_irq_d  = stat_line && !stat_line_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dot_q         <= '0;
            ly_q          <= '0;
            mode_q        <= MODE_HBLANK;
            running_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_irq_q  <= 1'b0;
            oam_locked_q  <= 1'b0;
            vram_locked_q <= 1'b0;
            stat_line_q   <= 1'b0;
            stat_irq_q    <= 1'b0;
        end else begin
            dot_q         <= dot_d;
            ly_q          <= ly_d;
            mode_q        <= mode_d;
            running_q     <= running_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_irq_q  <= vblank_irq_d;
            oam_locked_q  <= oam_locked_d;
            vram_locked_q <= vram_locked_d;
            stat_line_q   <= stat_line_d;
            stat_irq_q    <= stat_irq_d;
        end
    end

    assign mode        = mode_q;
    assign ly          = ly_q;
    assign dot         = dot_q;
    assign stat_irq    = stat_irq_q;
    assign vblank_irq  = vblank_irq_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign oam_locked  = oam_locked_q;
    assign vram_locked = vram_locked_q;

endmodule

// File: tb/tb_lcd_timing_controller.sv
// tb_lcd_timing_controller
//
// Bench for lcd_timing_controller. Every pulse the controller raises
// (line_start, frame_start, vblank_irq, stat_irq) is predicted by the stimulus
// and queued together with the ly/dot/mode it should appear with; a monitor
// pops and compares whenever a pulse shows up. Static state (reset values,
// mode lengths, locks, counter positions) is compared directly.
module tb_lcd_timing_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       dot_en;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic       int_lyc_en;
    logic       int_mode2_en;
    logic       int_mode1_en;
    logic       int_mode0_en;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [8:0] dot;
    logic       coincidence;
    logic       stat_irq;
    logic       vblank_irq;
    logic       line_start;
    logic       frame_start;
    logic       oam_locked;
    logic       vram_locked;

    typedef struct packed {
        logic       ls;
        logic       fs;
        logic       vb;
        logic       st;
        logic [7:0] ly;
        logic [8:0] dot;
        logic [1:0] mode;
    } pulse_rec_t;

    pulse_rec_t exp_q[$];
    int total = 0;
    int bad   = 0;

    lcd_timing_controller dut (
        .clk          (clk),
        .reset        (reset),
        .dot_en       (dot_en),
        .lcd_enable   (lcd_enable),
        .lyc          (lyc),
        .int_lyc_en   (int_lyc_en),
        .int_mode2_en (int_mode2_en),
        .int_mode1_en (int_mode1_en),
        .int_mode0_en (int_mode0_en),
        .mode         (mode),
        .ly           (ly),
        .dot          (dot),
        .coincidence  (coincidence),
        .stat_irq     (stat_irq),
        .vblank_irq   (vblank_irq),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .oam_locked   (oam_locked),
        .vram_locked  (vram_locked)
    );

    always #5 clk = ~clk;

    // Drive enable and dot strobe for one clock, then settle just past the edge.
    task automatic applyStimulus(input logic en, input logic de);
        lcd_enable = en;
        dot_en     = de;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectPulse(input logic ls, input logic fs, input logic vb, input logic st,
                               input int l, input int d, input int m);
        pulse_rec_t r;
        r.ls   = ls;
        r.fs   = fs;
        r.vb   = vb;
        r.st   = st;
        r.ly   = 8'(l);
        r.dot  = 9'(d);
        r.mode = 2'(m);
        exp_q.push_back(r);
    endtask

    // Monitor: any pulse must match the head of the expectation queue.
    initial begin
        pulse_rec_t act;
        pulse_rec_t exp;
        forever begin
            @(negedge clk);
            if (!reset && (line_start || frame_start || vblank_irq || stat_irq)) begin
                act = {line_start, frame_start, vblank_irq, stat_irq, ly, dot, mode};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: got ls=%0d fs=%0d vb=%0d st=%0d ly=%0d dot=%0d mode=%0d expected no pulse",
                             act.ls, act.fs, act.vb, act.st, act.ly, act.dot, act.mode);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        bad++;
                        $display("[TB] FAIL pulse: got ls=%0d fs=%0d vb=%0d st=%0d ly=%0d dot=%0d mode=%0d expected ls=%0d fs=%0d vb=%0d st=%0d ly=%0d dot=%0d mode=%0d",
                                 act.ls, act.fs, act.vb, act.st, act.ly, act.dot, act.mode,
                                 exp.ls, exp.fs, exp.vb, exp.st, exp.ly, exp.dot, exp.mode);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nl;
        int n2, n3, n0, nvram, noam;
        int exp_dot;
        logic de;

        reset        = 1'b1;
        lcd_enable   = 1'b1;
        dot_en       = 1'b1;
        lyc          = 8'd5;
        int_lyc_en   = 1'b0;
        int_mode2_en = 1'b0;
        int_mode1_en = 1'b0;
        int_mode0_en = 1'b0;
        n2 = 0; n3 = 0; n0 = 0; nvram = 0; noam = 0;

        // Reset state
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("reset_mode", mode, 0);
        checkOutput("reset_ly", ly, 0);
        checkOutput("reset_dot", dot, 0);
        checkOutput("reset_coincidence", coincidence, 0);
        checkOutput("reset_stat_irq", stat_irq, 0);
        checkOutput("reset_vblank_irq", vblank_irq, 0);
        checkOutput("reset_line_start", line_start, 0);
        checkOutput("reset_frame_start", frame_start, 0);
        checkOutput("reset_oam_locked", oam_locked, 0);
        checkOutput("reset_vram_locked", vram_locked, 0);

        // First enabled dot strobe starts the frame in OAM scan
        reset = 1'b0;
        expectPulse(1, 1, 0, 0, 0, 0, 2);
        applyStimulus(1'b1, 1'b1);
        checkOutput("start_mode", mode, 2);
        checkOutput("start_ly", ly, 0);

        // Full frame at one dot per clock; LYC=5 interrupt with mode 0 blocked
        int_lyc_en = 1'b1;
        for (int l = 0; l < 154; l++) begin
            for (int d = 0; d < 456; d++) begin
                if (d == 0 || d == 455) begin
                    checkOutput("line_ly", ly, l);
                    checkOutput("line_dot", dot, d);
                end
                if (l == 0) begin
                    if (mode == 2'd2) n2++;
                    if (mode == 2'd3) n3++;
                    if (mode == 2'd0) n0++;
                    if (vram_locked) nvram++;
                    if (oam_locked) noam++;
                    if (d == 79)  checkOutput("mode_at_79", mode, 2);
                    if (d == 80)  checkOutput("mode_at_80", mode, 3);
                    if (d == 251) checkOutput("mode_at_251", mode, 3);
                    if (d == 252) checkOutput("mode_at_252", mode, 0);
                end
                if (l == 5 && d == 10)  int_mode0_en = 1'b1;
                if (l == 5 && d == 400) int_mode0_en = 1'b0;
                if (l == 6 && d == 0)   int_lyc_en = 1'b0;
                if (l == 144 && d == 200) checkOutput("vblank_mode", mode, 1);
                if (d == 455) begin
                    nl = (l == 153) ? 0 : l + 1;
                    expectPulse(1, nl == 0, nl == 144, 0, nl, 0, (nl >= 144) ? 1 : 2);
                    if (nl == 5) expectPulse(0, 0, 0, 1, 5, 1, 2);
                end
                applyStimulus(1'b1, 1'b1);
            end
            if (l == 0) begin
                checkOutput("line0_mode2_dots", n2, 80);
                checkOutput("line0_mode3_dots", n3, 172);
                checkOutput("line0_mode0_dots", n0, 204);
                checkOutput("line0_vram_locked_dots", nvram, 172);
                checkOutput("line0_oam_locked_dots", noam, 252);
            end
        end
        checkOutput("wrap_ly", ly, 0);
        checkOutput("wrap_dot", dot, 0);

        // Run into line 3 transfer, then drop the enable mid-line
        for (int n = 0; n < 3 * 456 + 100; n++) begin
            if (n % 456 == 455) expectPulse(1, 0, 0, 0, n / 456 + 1, 0, 2);
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("pre_abort_ly", ly, 3);
        checkOutput("pre_abort_dot", dot, 100);
        checkOutput("pre_abort_mode", mode, 3);
        checkOutput("pre_abort_vram_locked", vram_locked, 1);
        checkOutput("pre_abort_oam_locked", oam_locked, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_ly", ly, 0);
        checkOutput("abort_dot", dot, 0);
        checkOutput("abort_mode", mode, 0);
        checkOutput("abort_vram_locked", vram_locked, 0);
        checkOutput("abort_oam_locked", oam_locked, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'(i % 2));
        checkOutput("disabled_hold_dot", dot, 0);
        checkOutput("disabled_hold_mode", mode, 0);

        // Re-enable with a dot strobe every 4th clock; LYC write between strobes
        exp_dot = -1;
        for (int i = 0; i < 1040; i++) begin
            de = (i % 4 == 0);
            if (de) begin
                if (exp_dot < 0) begin
                    exp_dot = 0;
                    expectPulse(1, 1, 0, 0, 0, 0, 2);
                end else begin
                    exp_dot++;
                end
            end
            if (i == 42) begin
                lyc        = 8'd0;
                int_lyc_en = 1'b1;
                expectPulse(0, 0, 0, 1, 0, 10, 2);
            end
            if (i == 50) begin
                int_lyc_en = 1'b0;
                lyc        = 8'd200;
            end
            applyStimulus(1'b1, de);
            checkOutput("sparse_dot", dot, exp_dot);
            checkOutput("sparse_vram_locked", vram_locked, (exp_dot >= 80 && exp_dot < 252) ? 1 : 0);
            if (i == 0) checkOutput("restart_mode", mode, 2);
        end

        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pulses_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
